mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the 128x8 level-sensitive RAM port (en/read/write/address/data).
//  Accepts single read, single write and block-fill requests from the CPU over a
//  valid/ready handshake, then drives the RAM strobes with safe setup/strobe/hold sequencing.
//  Returns one response pulse per request. Sits between the control unit and the RAM.
// PARAMETERS
//  ADDR_W      7   RAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W      8   RAM data width
//  STROBE_CYC  1   cycles mem_read/mem_write held high per access (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       controller idle; request accepted when valid&ready at clk edge
//  req_op       in   2       00 read, 01 write, 10 fill, 11 illegal
//  req_addr     in   ADDR_W  start address
//  req_wdata    in   DATA_W  write/fill byte
//  req_len      in   ADDR_W  fill count minus 1 (1..128 bytes); ignored for read/write
//  rsp_valid    out  1       one-cycle completion pulse
//  rsp_rdata    out  DATA_W  read data (valid with rsp_valid on read, else 0)
//  rsp_err      out  1       high with rsp_valid for illegal op
//  busy         out  1       ~req_ready
//  mem_en       out  1       RAM enable
//  mem_read     out  1       RAM read strobe
//  mem_write    out  1       RAM write strobe
//  mem_address  out  ADDR_W  RAM address
//  mem_wdata    out  DATA_W  RAM write data
//  mem_rdata    in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0 except req_ready=1; counters cleared.
//  req_* sampled only at the accepting edge; later changes ignored until next IDLE.
//  FSM: IDLE -> SETUP (1 cyc) -> STROBE (STROBE_CYC cyc) -> HOLD (1 cyc) -> RESP (1 cyc) -> IDLE.
//   - IDLE: req_ready=1, mem_en=0. On accept: legal op -> SETUP; op 11 -> RESP with rsp_err=1,
//     no RAM activity.
//   - SETUP: mem_en=1, strobes 0, mem_address/mem_wdata driven and stable.
//   - STROBE: mem_read=1 (read) or mem_write=1 (write/fill); address/data unchanged.
//     Read: mem_rdata registered at last STROBE edge into rsp_rdata.
//   - HOLD: strobes 0, mem_en=1, address/data unchanged (no write to a changing address).
//     Fill with remaining>0: address+1 (wrap 2**ADDR_W-1 -> 0), remaining-1, -> SETUP.
//     Otherwise -> RESP.
//   - RESP: mem_en=0, rsp_valid=1 one cycle; rsp_rdata=captured byte for read, 0 otherwise.
//  Invariants: mem_read&mem_write never both 1; strobes only with mem_en=1;
//   address/data never change while a strobe is high.
//  Latency (STROBE_CYC=1): rsp_valid in the 4th cycle after the accept edge for read/write;
//   fill of N bytes: 3N+1 cycles; illegal op: 1 cycle.
//  No response backpressure; rsp_rdata/rsp_err return to 0 after the pulse.
//  Reset mid-operation: abandon request, no rsp_valid; bytes already strobed stay written.
//  Back-to-back: new request may be accepted in the cycle following RESP.
// TESTING
//  1 Reset: assert rst_n=0 mid-clock -> outputs 0 immediately, req_ready=1 after release.
//  2 write 0x5A @0x10, then read @0x10 -> mem_write high exactly 1 cyc with addr 0x10;
//    read rsp_valid 4 cycles after accept, rsp_rdata=0x5A, rsp_err=0.
//  3 fill addr 0x7E len 3 data 0xAA -> writes 0x7E,0x7F,0x00,0x01 in order; rsp at cycle 13;
//    readback each = 0xAA, 0x02 unchanged.
//  4 op 11 -> rsp_valid+rsp_err next cycle, mem_en never asserted.
//  5 reset during fill 0x20 len 9 after 3rd HOLD -> only 0x20..0x22 written, no rsp_valid.
//  6 req_valid held high, req_* toggled while busy -> ignored; strobe exclusivity checked
//    by assertion throughout.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - RAM port initiator: read/write/fill requests sequenced as setup/strobe/hold
module mem_access_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   remaining_q;
  logic [CNT_W-1:0]    strobe_cnt_q;
  logic [DATA_W-1:0]   rdata_q;

  logic fill_more;
  assign fill_more = (op_q == OP_FILL) && (remaining_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = (req_op == OP_ILL) ? S_RESP : S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: if (strobe_cnt_q == STROBE_LAST) state_d = S_HOLD;
      S_HOLD:   state_d = fill_more ? S_SETUP : S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request fields are latched only at the accepting edge; the fill address advances in HOLD
  // so the next byte's address is already stable when its SETUP begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      remaining_q  <= '0;
      strobe_cnt_q <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            remaining_q <= (req_op == OP_FILL) ? req_len : '0;
            rdata_q     <= '0;
          end
        end
        S_SETUP: strobe_cnt_q <= '0;
        S_STROBE: begin
          strobe_cnt_q <= strobe_cnt_q + 1'b1;
          if (strobe_cnt_q == STROBE_LAST && op_q == OP_READ) rdata_q <= mem_rdata;
        end
        S_HOLD: begin
          if (fill_more) begin
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    mem_en      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_SETUP, S_STROBE, S_HOLD: begin
        mem_en      = 1'b1;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        if (state_q == S_STROBE) begin
          mem_read  = (op_q == OP_READ);
          mem_write = (op_q != OP_READ);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = (op_q == OP_ILL);
        rsp_rdata = (op_q == OP_READ) ? rdata_q : '0;
      end
      default: ;
    endcase
  end

  assign busy = ~req_ready;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench for mem_access_ctrl with a behavioural 128x8 RAM
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [6:0] req_addr, req_len;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic       mem_en, mem_read, mem_write;
  logic [6:0] mem_address;
  logic [7:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(7), .DATA_W(8), .STROBE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [7:0] ram [0:127];
  logic       ram_clear;

  assign mem_rdata = (mem_en && mem_read) ? ram[mem_address] : 8'h00;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'h00;
    end else if (mem_en && mem_write) begin
      ram[mem_address] <= mem_wdata;
    end
  end

  logic [6:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         en_cnt = 0;
  int         rsp_cnt = 0;
  int         viol_cnt = 0;
  logic       prev_strobe = 1'b0;
  logic [6:0] prev_addr = '0;
  logic [7:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write) begin
        wr_addr.push_back(mem_address);
        wr_data.push_back(mem_wdata);
      end
      if (mem_en) en_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (mem_read && mem_write) viol_cnt++;
      if ((mem_read || mem_write) && !mem_en) viol_cnt++;
      if ((mem_read || mem_write) && prev_strobe &&
          (mem_address != prev_addr || mem_wdata != prev_wdata)) viol_cnt++;
      prev_strobe = mem_read || mem_write;
      prev_addr   = mem_address;
      prev_wdata  = mem_wdata;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [6:0] addr, input logic [7:0] wd,
                        input logic [6:0] len, output int lat, output logic [7:0] rd,
                        output logic er);
    lat = 0;
    rd  = 8'h00;
    er  = 1'b0;
    @(negedge clk);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_len   = len;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
  endtask

  int         lat, wb, rc, eb;
  logic [7:0] rd;
  logic       er;
  logic [6:0] fill_exp [4];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
    req_wdata = '0; req_len = '0; ram_clear = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    ram_clear = 1'b0;
    rst_n = 1'b1;

    // 1: asynchronous reset while a write strobe is high
    @(negedge clk);
    req_op = 2'b01; req_addr = 7'h40; req_wdata = 8'h11; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_strobe", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_write", mem_write, 0);
    check("mid_rst_address", mem_address, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("post_rst_ready", req_ready, 1);

    // 2: write then read back
    wb = wr_addr.size();
    do_req(2'b01, 7'h10, 8'h5A, 7'd0, lat, rd, er);
    check("wr_latency", lat, 4);
    check("wr_err", er, 0);
    check("wr_rdata_zero", rd, 0);
    check("wr_strobe_cycles", wr_addr.size() - wb, 1);
    check("wr_addr", wr_addr[wb], 7'h10);
    check("wr_data", wr_data[wb], 8'h5A);
    do_req(2'b00, 7'h10, 8'h00, 7'd0, lat, rd, er);
    check("rd_latency", lat, 4);
    check("rd_data", rd, 8'h5A);
    check("rd_err", er, 0);
    @(negedge clk);
    check("rd_rdata_cleared", rsp_rdata, 0);

    // 3: fill wrapping past the top of the address space
    do_req(2'b01, 7'h02, 8'h33, 7'd0, lat, rd, er);
    wb = wr_addr.size();
    do_req(2'b10, 7'h7E, 8'hAA, 7'd3, lat, rd, er);
    check("fill_latency", lat, 13);
    check("fill_err", er, 0);
    check("fill_count", wr_addr.size() - wb, 4);
    fill_exp[0] = 7'h7E; fill_exp[1] = 7'h7F; fill_exp[2] = 7'h00; fill_exp[3] = 7'h01;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_addr%0d", i), wr_addr[wb+i], fill_exp[i]);
      check($sformatf("fill_data%0d", i), wr_data[wb+i], 8'hAA);
      do_req(2'b00, fill_exp[i], 8'h00, 7'd0, lat, rd, er);
      check($sformatf("fill_readback%0d", i), rd, 8'hAA);
    end
    do_req(2'b00, 7'h02, 8'h00, 7'd0, lat, rd, er);
    check("fill_neighbour", rd, 8'h33);

    // 4: illegal op
    eb = en_cnt;
    do_req(2'b11, 7'h05, 8'h99, 7'd0, lat, rd, er);
    check("ill_latency", lat, 1);
    check("ill_err", er, 1);
    check("ill_rdata", rd, 0);
    check("ill_no_mem_en", en_cnt - eb, 0);
    @(negedge clk);
    check("ill_err_cleared", rsp_err, 0);

    // 5: reset during a fill just after the third HOLD
    wb = wr_addr.size();
    @(negedge clk);
    req_op = 2'b10; req_addr = 7'h20; req_wdata = 8'h77; req_len = 7'd9; req_valid = 1'b1;
    @(posedge clk);
    rc = rsp_cnt;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_rsp", rsp_cnt - rc, 0);
    check("abort_write_count", wr_addr.size() - wb, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("abort_addr%0d", i), wr_addr[wb+i], 7'h20 + 7'(i));
    do_req(2'b00, 7'h22, 8'h00, 7'd0, lat, rd, er);
    check("abort_last_written", rd, 8'h77);
    do_req(2'b00, 7'h23, 8'h00, 7'd0, lat, rd, er);
    check("abort_not_written", rd, 8'h00);

    // 6: req_valid held high with request fields churning while busy
    wb = wr_addr.size();
    lat = 0; er = 1'b1;
    @(negedge clk);
    req_op = 2'b01; req_addr = 7'h30; req_wdata = 8'h3C; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        er  = rsp_err;
        req_valid = 1'b0;
        break;
      end
      req_op    = 2'($urandom_range(0, 3));
      req_addr  = 7'($urandom);
      req_wdata = 8'($urandom);
    end
    check("hold_latency", lat, 4);
    check("hold_err", er, 0);
    check("hold_write_count", wr_addr.size() - wb, 1);
    check("hold_addr", wr_addr[wb], 7'h30);
    check("hold_data", wr_data[wb], 8'h3C);
    @(negedge clk);
    check("back_to_back_ready", req_ready, 1);
    do_req(2'b00, 7'h30, 8'h00, 7'd0, lat, rd, er);
    check("hold_readback", rd, 8'h3C);

    check("strobe_invariants", viol_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
